sprite_animator: RTL and testbench
==================================

Name: sprite_animator

Overview:
- Parametrised successor to the two-frame Pac-Man mouth toggler.
- Steps through FRAMES animation frames of a SIZE x SIZE right-facing bitmap held in an external synchronous ROM.
- Supports loop, ping-pong and play-once modes, and divides the game tick down to the frame rate.
- Derives up/left/down orientations by geometric transform, so no per-direction bitmaps are stored. Feeds the VGA sprite drawer.

Parameters:
- SIZE, 5, sprite edge in pixels; bitmap width is SIZE*SIZE.
- FRAMES, 4, animation frames stored in ROM (>=1).
- FAW, 2, frame-index width; must satisfy 2^FAW >= FRAMES.
- DIV, 2, enable pulses per frame step (>=1).

Ports:
- clock  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  game tick; one-cycle pulse.
- rotation  in  2  0 right, 1 up, 2 left, 3 down.
- mode  in  2  0 loop, 1 ping-pong, 2 play-once, 3 same as loop.
- rom_addr  out  FAW  frame address to ROM; equals frame_idx.
- rom_data  in  SIZE*SIZE  right-facing bitmap; valid one clock after rom_addr.
- out  out  SIZE*SIZE  oriented bitmap.
- out_valid  out  1  out holds real ROM data.
- frame_idx  out  FAW  current frame register.
- done  out  1  one-cycle pulse on wrap (loop), return to 0 (ping-pong), or reaching FRAMES-1 (play-once).

Behaviour:
- Pixel mapping: pixel (r,c), row 0 at top, is bit SIZE*SIZE-1-(r*SIZE+c), i.e. MSB is top-left.
- Transforms (I = rom_data, O = out):
  - rot 0: O(r,c)=I(r,c).
  - rot 1: O(r,c)=I(c,SIZE-1-r); rotate CCW, so the mouth moves to the top.
  - rot 2: O(r,c)=I(r,SIZE-1-c); horizontal mirror, not a 180° turn, so the eye stays on top.
  - rot 3: O(r,c)=I(SIZE-1-c,r); rotate CW.
- Reset (resetn low at an edge) sets:
  - frame_idx=0, divider=0, direction=forward, held=0.
  - out=0, out_valid=0, done=0.
  - Reset overrides enable. It may arrive mid-animation; everything restarts from frame 0.
- Divider:
  - Counts enable pulses from 0 to DIV-1.
  - An enable pulse at count DIV-1 is a "step"; the counter returns to 0 on that pulse.
  - enable low leaves all state frozen.
  - DIV=1 makes every enable pulse a step.
- Frame update on a step:
  - Loop: idx = (idx==FRAMES-1) ? 0 : idx+1; done pulses on the 0 transition.
  - Ping-pong, forward:
    - at FRAMES-1, flip to backward and step to idx-1;
    - otherwise idx+1.
  - Ping-pong, backward:
    - at 0, flip to forward and step to idx+1;
    - otherwise idx-1;
    - done pulses when idx becomes 0.
  - Play-once:
    - advance to FRAMES-1;
    - on reaching it, set held and pulse done;
    - further steps do nothing while held.
  - FRAMES=1: idx stays 0; done pulses every step in every mode; the ping-pong direction still toggles.
  - mode is sampled only on steps.
  - held clears on reset or on any step with mode != 2.
  - Entering loop mode with direction=backward resets direction to forward.
- Timing:
  - frame_idx and done register at step edge E; rom_addr reflects the new index after E.
  - The ROM returns data after edge E+1.
  - out <= transform(rom_data, rotation) at every edge after reset.
  - Net latency: frame change on out is 2 edges after the step edge; rotation change on out is 1 edge.
- out_valid:
  - Low through reset.
  - Goes high at the 2nd edge after resetn is first sampled high, then stays high.
  - out is unconditionally reloaded each cycle, so the first valid value is frame 0.
- done is high for exactly one cycle per qualifying step, and is never high during reset.

Test Plan:
- Reset, then hold resetn high with enable low: out_valid=0 for 1 edge and 1 from the 2nd edge; rom_addr=0; out = transform of ROM[0]; done never pulses.
- Loop mode, DIV=2, FRAMES=4, enable every cycle:
  - frame_idx sequence 0,0,1,1,2,2,3,3,0;
  - done pulses once, at the 3→0 step;
  - out tracks rom_data with 2-edge lag.
- Ping-pong with enable pulses: frame_idx 0,1,2,3,2,1,0,1; done pulses only on the 1→0 step; direction flips at 3 and 0.
- Play-once: frame_idx 0,1,2,3 then holds 3 under further pulses; done pulses once. Switch mode to 0: next step gives 0 and a second done.
- ROM[0]=25'b0111011111110001111101110, sweep rotation 0..3 one cycle apart:
  - out equals 25'b0111011111110001111101110, then 25'b0101011011110111111101110, then 25'b0111011111000111111101110, then 25'b0111011111110111101101010;
  - each appears 1 edge after its rotation value.
- Assert resetn low mid-animation at frame 2: the next edge gives frame_idx=0, out=0, out_valid=0, divider cleared; recovery matches the first scenario.

Source files
------------

// File: rtl/sprite_animator.sv
// Frame sequencer for an animated sprite held in an external synchronous ROM.
// It divides the game tick down to the frame rate and orients the bitmap on the way out.

module sprite_animator_pix (
  input  logic [3:0] cand,
  input  logic [1:0] rotation,
  output logic       pix
);
  assign pix = cand[rotation];
endmodule

module sprite_animator #(
  parameter int SIZE   = 5,
  parameter int FRAMES = 4,
  parameter int FAW    = 2,
  parameter int DIV    = 2
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   enable,
  input  logic [1:0]             rotation,
  input  logic [1:0]             mode,
  output logic [FAW-1:0]         rom_addr,
  input  logic [SIZE*SIZE-1:0]   rom_data,
  output logic [SIZE*SIZE-1:0]   out,
  output logic                   out_valid,
  output logic [FAW-1:0]         frame_idx,
  output logic                   done
);
  localparam int N      = SIZE * SIZE;
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int STAGES = 1;
  localparam logic [FAW-1:0] LAST   = FAW'(FRAMES - 1);
  localparam logic [DW-1:0]  DC_TOP = DW'(DIV - 1);

  typedef enum logic {FWD = 1'b0, BWD = 1'b1} dir_e;

  function automatic int pix_bit(input int r, input int c);
    return N - 1 - (r * SIZE + c);
  endfunction

  logic [DW-1:0]     div_cnt;
  dir_e              dir, ndir;
  logic              held, nheld, ndone;
  logic [FAW-1:0]    nidx;
  logic              step, at_last, at_zero;
  logic [STAGES:0]   vld_pipe;
  logic [N-1:0]      xf;

  assign step     = enable && (div_cnt == DC_TOP);
  assign at_last  = (frame_idx == LAST);
  assign at_zero  = (frame_idx == '0);
  assign rom_addr = frame_idx;
  assign out_valid = vld_pipe[STAGES];

  always_comb begin
    nidx  = frame_idx;
    ndir  = dir;
    nheld = held;
    ndone = 1'b0;
    unique case (mode)
      2'd1: begin
        nheld = 1'b0;
        if (FRAMES == 1) begin
          nidx = '0;
          ndir = (dir == FWD) ? BWD : FWD;
        end else if (dir == FWD) begin
          if (at_last) begin
            ndir = BWD;
            nidx = frame_idx - 1'b1;
          end else begin
            nidx = frame_idx + 1'b1;
          end
        end else begin
          if (at_zero) begin
            ndir = FWD;
            nidx = frame_idx + 1'b1;
          end else begin
            nidx = frame_idx - 1'b1;
          end
        end
        ndone = (nidx == '0);
      end
      2'd2: begin
        // Held after reaching the last frame; a single-frame sprite still reports every step.
        if (!held) begin
          nidx = at_last ? frame_idx : frame_idx + 1'b1;
          if (nidx == LAST) begin
            nheld = 1'b1;
            ndone = 1'b1;
          end
        end else begin
          ndone = (FRAMES == 1);
        end
      end
      default: begin
        nheld = 1'b0;
        ndir  = FWD;
        nidx  = at_last ? '0 : frame_idx + 1'b1;
        ndone = at_last;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      frame_idx <= '0;
      div_cnt   <= '0;
      dir       <= FWD;
      held      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (enable) begin
        div_cnt <= step ? '0 : div_cnt + 1'b1;
      end
      if (step) begin
        frame_idx <= nidx;
        dir       <= ndir;
        held      <= nheld;
        done      <= ndone;
      end
    end
  end

  // ROM data trails rom_addr by one edge, so out becomes meaningful on the second edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld_pipe <= '0;
      out      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
      out      <= xf;
    end
  end

  for (genvar r = 0; r < SIZE; r++) begin : g_row
    for (genvar c = 0; c < SIZE; c++) begin : g_col
      localparam int P0 = pix_bit(r, c);
      localparam int P1 = pix_bit(c, SIZE - 1 - r);
      localparam int P2 = pix_bit(r, SIZE - 1 - c);
      localparam int P3 = pix_bit(SIZE - 1 - c, r);
      sprite_animator_pix u_pix (
        .cand     ({rom_data[P3], rom_data[P2], rom_data[P1], rom_data[P0]}),
        .rotation (rotation),
        .pix      (xf[P0])
      );
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// Randomised scoreboard bench for sprite_animator against a behavioural frame/orientation model.
module tb_sprite_animator;
  localparam int SIZE = 5, FRAMES = 4, FAW = 2, DIV = 2;
  localparam int N = SIZE * SIZE;

  logic           clock = 1'b0;
  logic           resetn = 1'b0;
  logic           enable = 1'b0;
  logic [1:0]     rotation = 2'd0;
  logic [1:0]     mode = 2'd0;
  logic [FAW-1:0] rom_addr;
  logic [N-1:0]   rom_data;
  logic [N-1:0]   out;
  logic           out_valid;
  logic [FAW-1:0] frame_idx;
  logic           done;

  logic [N-1:0] rom [FRAMES];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           idx;
    bit           done;
    bit           valid;
    bit           chk_out;
    logic [N-1:0] out;
  } exp_t;
  exp_t sb[$];

  sprite_animator #(.SIZE(SIZE), .FRAMES(FRAMES), .FAW(FAW), .DIV(DIV)) dut (
    .clock(clock), .resetn(resetn), .enable(enable), .rotation(rotation), .mode(mode),
    .rom_addr(rom_addr), .rom_data(rom_data), .out(out), .out_valid(out_valid),
    .frame_idx(frame_idx), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  // Orientation straight from the pixel equations: O(r,c) = I(source row, source col).
  function automatic logic [N-1:0] orient(input logic [N-1:0] img, input int rot);
    logic [N-1:0] o;
    int sr, sc;
    o = '0;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        case (rot)
          1:       begin sr = c;            sc = SIZE - 1 - r; end
          2:       begin sr = r;            sc = SIZE - 1 - c; end
          3:       begin sr = SIZE - 1 - c; sc = r;            end
          default: begin sr = r;            sc = c;            end
        endcase
        o[N - 1 - (r * SIZE + c)] = img[N - 1 - (sr * SIZE + sc)];
      end
    end
    return o;
  endfunction

  // Reference model: tick count, frame position, direction and hold flag as plain integers.
  int  m_idx, m_ticks, m_since_rst, m_p1, m_p2;
  bit  m_back, m_held, m_done;
  always @(posedge clock) begin
    exp_t e;
    if (!resetn) begin
      m_idx = 0; m_ticks = 0; m_back = 0; m_held = 0; m_done = 0; m_since_rst = 0;
      e.out = '0; e.chk_out = 1;
      m_p2 = m_p1; m_p1 = 0;
    end else begin
      m_since_rst++;
      e.out = orient(rom[m_p2], rotation);
      e.chk_out = (m_since_rst >= 2);
      m_done = 0;
      if (enable) begin
        m_ticks++;
        if (m_ticks == DIV) begin
          m_ticks = 0;
          if (mode == 2'd1) begin
            m_held = 0;
            if (FRAMES == 1) m_back = !m_back;
            else if (!m_back) begin
              if (m_idx == FRAMES - 1) begin m_back = 1; m_idx--; end else m_idx++;
            end else begin
              if (m_idx == 0) begin m_back = 0; m_idx++; end else m_idx--;
            end
            m_done = (m_idx == 0);
          end else if (mode == 2'd2) begin
            if (!m_held) begin
              if (m_idx < FRAMES - 1) m_idx++;
              if (m_idx == FRAMES - 1) begin m_held = 1; m_done = 1; end
            end
          end else begin
            m_held = 0; m_back = 0;
            m_idx = (m_idx + 1) % FRAMES;
            m_done = (m_idx == 0);
          end
        end
      end
      m_p2 = m_p1; m_p1 = m_idx;
    end
    e.idx = m_idx;
    e.done = m_done;
    e.valid = resetn && (m_since_rst >= 2);
    sb.push_back(e);
  end

  always @(negedge clock) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (frame_idx !== FAW'(e.idx)) begin errors++; $display("FAIL frame_idx got %0d want %0d at %0t", frame_idx, e.idx, $time); end
      checks++;
      if (rom_addr !== FAW'(e.idx)) begin errors++; $display("FAIL rom_addr got %0d want %0d at %0t", rom_addr, e.idx, $time); end
      checks++;
      if (done !== e.done) begin errors++; $display("FAIL done got %b want %b at %0t", done, e.done, $time); end
      checks++;
      if (out_valid !== e.valid) begin errors++; $display("FAIL out_valid got %b want %b at %0t", out_valid, e.valid, $time); end
      if (e.chk_out) begin
        checks++;
        if (out !== e.out) begin errors++; $display("FAIL out got %h want %h at %0t", out, e.out, $time); end
      end
    end
  end

  task automatic cyc(input bit en, input logic [1:0] md, input int n);
    repeat (n) begin
      @(negedge clock);
      enable = en; mode = md;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    resetn = 1'b0; enable = 1'b0;
    repeat (n) @(negedge clock);
    resetn = 1'b1;
  endtask

  logic [N-1:0] sprite = 25'b0111011111110001111101110;
  logic [N-1:0] rot_exp [4];

  initial begin
    rot_exp[0] = 25'b0111011111110001111101110;
    rot_exp[1] = 25'b0101011011110111111101110;
    rot_exp[2] = 25'b0111011111000111111101110;
    rot_exp[3] = 25'b0111011111110111101101010;
    rom[0] = sprite;
    for (int i = 1; i < FRAMES; i++) rom[i] = N'($urandom);

    repeat (3) @(negedge clock);
    resetn = 1'b1;
    cyc(0, 2'd0, 6);                                  // idle after reset
    cyc(1, 2'd0, 12);                                 // loop, enable every cycle
    do_reset(2);
    for (int i = 0; i < 10; i++) begin               // ping-pong, enable pulses
      cyc(1, 2'd1, 1); cyc(0, 2'd1, 1);
    end
    for (int i = 0; i < 6; i++) cyc(1, 2'd1, 1);
    do_reset(2);
    cyc(1, 2'd2, 14);                                 // play-once, then hold
    cyc(1, 2'd0, 4);                                  // back to loop: wraps to 0

    do_reset(2);
    cyc(0, 2'd0, 3);
    rotation = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (out !== rot_exp[k]) begin
        errors++; $display("FAIL rot_sweep%0d got %b want %b", k, out, rot_exp[k]);
      end
      if (k < 3) rotation = 2'(k + 1);
    end

    cyc(1, 2'd0, 4);                                  // reach frame 2, then reset mid-run
    do_reset(1);
    cyc(0, 2'd0, 4);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b0;
        for (int j = 0; j < FRAMES; j++) rom[j] = N'($urandom);
      end else resetn = 1'b1;
      enable = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      rotation = 2'($urandom_range(0, 3));
    end
    @(negedge clock);
    enable = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
